// File: rtl/demux2_stream_pkg.sv
// demux2_stream_pkg: shared types and helpers for the two-way stream demultiplexer.
// The optional delivered-beat counters are enabled with DEMUX2_STREAM_CNT_EN.
package demux2_stream_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    // Pointer width for a power-of-two FIFO depth; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        if (depth <= 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/demux2_fifo.sv
// demux2_fifo: small synchronous FIFO used once per demux output.
// Head entry is driven straight from the storage registers, so a pushed
// beat becomes visible one cycle after the push edge. Push is ignored when
// full and pop is ignored when empty.
module demux2_fifo
    import demux2_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Status flags and qualified push/pop strobes.
    always_comb begin
        w_full    = (r_count == CNT_MAX);
        w_empty   = (r_count == {CW{1'b0}});
        w_push_ok = i_push && !w_full;
        w_pop_ok  = i_pop && !w_empty;
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: one valid/ready stream routed onto two outputs by in_sel
// (0 -> out1, 1 -> out2), each output buffered by its own FIFO so a stalled
// consumer only blocks beats headed to it.
// Optional per-output delivered-beat counters: define DEMUX2_STREAM_CNT_EN.
module demux2_stream
    import demux2_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data
`ifdef DEMUX2_STREAM_CNT_EN
    ,
    output cnt_t             out1_cnt,
    output cnt_t             out2_cnt
`endif
);

    logic w_full1;
    logic w_full2;
    logic w_empty1;
    logic w_empty2;
    logic w_in_ready;
    logic w_push1;
    logic w_push2;
    logic w_pop1;
    logic w_pop2;

    // Ready follows the selected FIFO only; no pass-through when full.
    always_comb begin
        if (in_sel) begin
            w_in_ready = !w_full2;
        end else begin
            w_in_ready = !w_full1;
        end
        w_push1 = in_valid && w_in_ready && !in_sel;
        w_push2 = in_valid && w_in_ready && in_sel;
        w_pop1  = out1_ready && !w_empty1;
        w_pop2  = out2_ready && !w_empty2;
    end

    demux2_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push1),
        .i_data  (in_data),
        .i_pop   (w_pop1),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_data  (out1_data)
    );

    demux2_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push2),
        .i_data  (in_data),
        .i_pop   (w_pop2),
        .o_full  (w_full2),
        .o_empty (w_empty2),
        .o_data  (out2_data)
    );

    assign in_ready   = w_in_ready;
    assign out1_valid = !w_empty1;
    assign out2_valid = !w_empty2;

`ifdef DEMUX2_STREAM_CNT_EN
    cnt_t r_cnt1;
    cnt_t r_cnt2;

    // Delivered-beat counters; wrap at 16 bits, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt1 <= {CNT_W{1'b0}};
            r_cnt2 <= {CNT_W{1'b0}};
        end else begin
            if (w_pop1) begin
                r_cnt1 <= r_cnt1 + cnt_t'(1);
            end else begin
                r_cnt1 <= r_cnt1;
            end
            if (w_pop2) begin
                r_cnt2 <= r_cnt2 + cnt_t'(1);
            end else begin
                r_cnt2 <= r_cnt2;
            end
        end
    end

    assign out1_cnt = r_cnt1;
    assign out2_cnt = r_cnt2;
`endif

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Two-way stream demultiplexer: the counterpart of the 2:1 mux, distributing one valid/ready input stream onto two output streams by a per-beat select bit. Each output has a small FIFO, so a stalled output does not block beats headed to the other output once they are queued. It sits between a single producer and two consumers in the datapath, and is the inverse routing element of the MUX2 cell.

## Interface
- WIDTH, 8, data bits per beat
- DEPTH, 2, entries per output FIFO; power of two, at least 2
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  producer has a beat
- in_ready  output  1  beat is accepted this cycle when in_valid is also high
- in_data  input  WIDTH  beat payload
- in_sel  input  1  routing: 0 sends the beat to out1, 1 sends it to out2 (same polarity as MUX2 sel)
- out1_valid / out2_valid  output  1  FIFO non-empty
- out1_ready / out2_ready  input  1  consumer takes the head entry
- out1_data / out2_data  output  WIDTH  head entry of the FIFO
- out1_cnt / out2_cnt  output  16  delivered-beat counters; present only with the macro

## Operation
- Accept: in_valid && in_ready. The beat is pushed into FIFO[in_sel].
- in_ready = !full[in_sel]. It is a combinational function of in_sel and registered state only; it never depends on in_valid.
- Pop: outN_valid && outN_ready. The head advances at the clock edge.
- outN_valid = (count_N != 0); outN_data = mem_N[rd_ptr_N], driven combinationally from registers.
- FIFO state per output:
  - rd_ptr and wr_ptr: log2(DEPTH) bits, wrapping modulo DEPTH.
  - count: log2(DEPTH)+1 bits, range 0..DEPTH.
- Simultaneous push and pop on the same FIFO:
  - count is unchanged and both pointers advance.
  - This is legal only when the FIFO is not full, because in_ready gates the push.
- Full FIFO with pop in the same cycle: in_ready stays low for that FIFO this cycle. There is no same-cycle pass-through; the freed slot is usable next cycle.
- Beats to the unselected output are unaffected by the selected FIFO's state. Ordering is preserved within each output; no ordering is defined across outputs.
- Pushes to both FIFOs in one cycle are impossible, since there is only one input beat per cycle.
- in_sel and in_data are ignored when in_valid is low.

## Timing
- Latency: a beat accepted at edge k appears on outN_valid/outN_data in cycle k+1 (one register stage). There is no combinational in→out path.
- Throughput: one beat per cycle per FIFO while the consumer keeps ready high, with DEPTH ≥ 2.
- Reset (rst_n low at a rising edge):
  - pointers and counts become 0;
  - out1_valid and out2_valid become 0;
  - memories and out*_data become 0;
  - counters become 0.
- in_ready is 1 after reset, because both FIFOs are empty.
- Reset mid-operation discards all queued beats. No pop is reported and counters do not advance in the reset cycle.
- outN_data is stable while outN_valid is high and outN_ready is low.

## Configuration
- DEMUX2_STREAM_CNT_EN
  - Defined: out1_cnt and out2_cnt exist. Each increments by 1 on every pop of its output and wraps from 0xFFFF to 0x0000. Each is reset to 0.
  - Undefined: the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package demux2_stream_pkg:
  - CNT_W = 16;
  - typedef for the counter type;
  - function clog2-based pointer width helper.
- Sub-module demux2_fifo:
  - parameters WIDTH and DEPTH;
  - push/pop/full/empty plus head data;
  - instantiated twice.
- The top level holds the select decode, the in_ready mux and, optionally, the counters.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → in_ready=1, both valid=0, data=0, counters=0.
- Routing:
  - Stimulus: push 0xA1 (sel=0), then 0xB2 (sel=1), with both readies high.
  - Required: out1 shows 0xA1 in cycle k+1, out2 shows 0xB2 in cycle k+2.
  - Required with the macro: each counter reads 1.
- Backpressure isolation:
  - Stimulus: out1_ready=0; push 0x01, 0x02 to out1.
  - Required: with sel=0, in_ready=0; with sel=1, in_ready=1, and 0x03 reaches out2.
  - Then set out1_ready=1. Required: out1 delivers 0x01, then 0x02, in order.
- Full with pop:
  - Stimulus: out1 FIFO full, pop in cycle k, in_valid sel=0.
  - Required: in_ready=0 in cycle k, 1 in cycle k+1.
- Streaming wrap:
  - Stimulus: 10 consecutive beats 0x00–0x09 to out2, ready always high.
  - Required: one beat delivered per cycle, in order, and the pointers wrap correctly.
- Mid-operation reset:
  - Stimulus: rst_n=0 with 2 entries queued.
  - Required: next cycle both valid=0, and the counters are not incremented by the discarded entries.
